// File: rtl/ula_contention_ctrl.sv
// rtl/ula_contention_ctrl.sv - ULA CPU clock generation, video fetch slots and
// contention stretching for the shared lower RAM.
module ula_contention_ctrl #(
  parameter int unsigned STALL_END   = 6,
  parameter int unsigned FETCH_SLOTS = 4,
  parameter bit          IO_CONTEND  = 1'b1
) (
  input  logic       OSC,
  input  logic       n_RESET,
  input  logic       VID_ACTIVE,
  input  logic       n_MREQ,
  input  logic       n_IOREQ,
  input  logic       A15,
  input  logic       A14,
  input  logic       A0,
  output logic       CPU_CLK,
  output logic       CONTEND,
  output logic       VID_FETCH,
  output logic [1:0] VID_SLOT,
  output logic       VID_LATCH,
  output logic [2:0] TSTATE
);

  localparam logic [2:0] STALL_END_TS = 3'(STALL_END);
  localparam logic [3:0] FETCH_LIMIT  = 4'(FETCH_SLOTS);

  logic [4:0] cnt_q, cnt_d;
  logic       win_q, win_d;
  logic       stall_q, stall_d;
  logic       served_q, served_d;
  logic       cpu_clk_q, cpu_clk_d;
  logic       contend_q, contend_d;
  logic       vid_fetch_q, vid_fetch_d;
  logic [1:0] vid_slot_q, vid_slot_d;
  logic       vid_latch_q, vid_latch_d;
  logic [2:0] tstate_q, tstate_d;

  logic [2:0] ts_d;
  logic [1:0] sub_d;
  logic       req;
  logic       mem_req;
  logic       io_req;
  logic       bus_idle;
  logic       fall_edge;

  assign mem_req  = !n_MREQ && !A15 && A14;
  assign io_req   = IO_CONTEND && !n_IOREQ && !A0;
  assign req      = mem_req || io_req;
  assign bus_idle = n_MREQ && n_IOREQ;

  // Timebase and window latch; every output below decodes the next CNT value.
  always_comb begin
    cnt_d = cnt_q + 5'd1;
    ts_d  = cnt_d[4:2];
    sub_d = cnt_d[1:0];
    win_d = win_q;
    if (cnt_d == 5'd0) begin
      win_d = VID_ACTIVE;
    end
    fall_edge = (sub_d == 2'd0);
  end

  // Stall decisions only on the would-be falling CPU edge so CPU_CLK never glitches.
  always_comb begin
    stall_d  = stall_q;
    served_d = served_q;
    if (fall_edge) begin
      if (stall_q) begin
        if (ts_d == STALL_END_TS) begin
          stall_d  = 1'b0;
          served_d = 1'b1;
        end
      end else if (req && !served_q && win_d && (ts_d < STALL_END_TS)) begin
        stall_d = 1'b1;
      end else if (req) begin
        served_d = 1'b1;
      end
    end
    if (bus_idle) begin
      served_d = 1'b0;
    end
  end

  always_comb begin
    cpu_clk_d   = stall_d ? 1'b1 : cnt_d[1];
    contend_d   = stall_d;
    vid_fetch_d = win_d && ({1'b0, ts_d} < FETCH_LIMIT);
    vid_slot_d  = vid_fetch_d ? ts_d[1:0] : 2'd0;
    vid_latch_d = vid_fetch_d && (sub_d == 2'd3);
    tstate_d    = ts_d;
  end

  always_ff @(posedge OSC or negedge n_RESET) begin
    if (!n_RESET) begin
      cnt_q       <= 5'd0;
      win_q       <= 1'b0;
      stall_q     <= 1'b0;
      served_q    <= 1'b0;
      cpu_clk_q   <= 1'b1;
      contend_q   <= 1'b0;
      vid_fetch_q <= 1'b0;
      vid_slot_q  <= 2'd0;
      vid_latch_q <= 1'b0;
      tstate_q    <= 3'd0;
    end else begin
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      stall_q     <= stall_d;
      served_q    <= served_d;
      cpu_clk_q   <= cpu_clk_d;
      contend_q   <= contend_d;
      vid_fetch_q <= vid_fetch_d;
      vid_slot_q  <= vid_slot_d;
      vid_latch_q <= vid_latch_d;
      tstate_q    <= tstate_d;
    end
  end

  assign CPU_CLK   = cpu_clk_q;
  assign CONTEND   = contend_q;
  assign VID_FETCH = vid_fetch_q;
  assign VID_SLOT  = vid_slot_q;
  assign VID_LATCH = vid_latch_q;
  assign TSTATE    = tstate_q;

endmodule

// File: tb/tb_ula_contention_ctrl.sv
// tb/tb_ula_contention_ctrl.sv - directed self-checking bench for ula_contention_ctrl.
module tb_ula_contention_ctrl;

  logic       OSC = 1'b0;
  logic       n_RESET = 1'b0;
  logic       VID_ACTIVE = 1'b0;
  logic       n_MREQ = 1'b1;
  logic       n_IOREQ = 1'b1;
  logic       A15 = 1'b0;
  logic       A14 = 1'b0;
  logic       A0 = 1'b1;
  logic       CPU_CLK;
  logic       CONTEND;
  logic       VID_FETCH;
  logic [1:0] VID_SLOT;
  logic       VID_LATCH;
  logic [2:0] TSTATE;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] cnt;

  ula_contention_ctrl #(
    .STALL_END  (6),
    .FETCH_SLOTS(4),
    .IO_CONTEND (1'b1)
  ) dut (
    .OSC       (OSC),
    .n_RESET   (n_RESET),
    .VID_ACTIVE(VID_ACTIVE),
    .n_MREQ    (n_MREQ),
    .n_IOREQ   (n_IOREQ),
    .A15       (A15),
    .A14       (A14),
    .A0        (A0),
    .CPU_CLK   (CPU_CLK),
    .CONTEND   (CONTEND),
    .VID_FETCH (VID_FETCH),
    .VID_SLOT  (VID_SLOT),
    .VID_LATCH (VID_LATCH),
    .TSTATE    (TSTATE)
  );

  always #5 OSC = ~OSC;

  // Bench-side position within the 32-OSC period.
  always @(posedge OSC or negedge n_RESET) begin
    if (!n_RESET) cnt <= 5'd0;
    else          cnt <= cnt + 5'd1;
  end

  task automatic wait_cnt(input logic [4:0] v);
    int n;
    n = 0;
    @(negedge OSC);
    while (cnt != v && n < 64) begin
      @(negedge OSC);
      n++;
    end
  endtask

  task automatic test_reset();
    n_RESET = 1'b0;
    repeat (3) @(negedge OSC);
    vectors++;
    if ({CPU_CLK, CONTEND, VID_FETCH, VID_SLOT, VID_LATCH, TSTATE} !== 9'b1_0_0_00_0_000) begin
      miscompares++;
      $display("FAIL reset_outputs got clk=%b cont=%b fetch=%b slot=%0d latch=%b ts=%0d want 1 0 0 0 0 0",
               CPU_CLK, CONTEND, VID_FETCH, VID_SLOT, VID_LATCH, TSTATE);
    end
    n_RESET = 1'b1;
  endtask

  task automatic test_free_run();
    VID_ACTIVE = 1'b0;
    for (int j = 0; j < 64; j++) begin
      @(negedge OSC);
      vectors++;
      if (CPU_CLK !== cnt[1] || CONTEND !== 1'b0 || VID_FETCH !== 1'b0 || TSTATE !== cnt[4:2]) begin
        miscompares++;
        $display("FAIL free_run cnt=%0d got clk=%b cont=%b fetch=%b ts=%0d want clk=%b cont=0 fetch=0 ts=%0d",
                 cnt, CPU_CLK, CONTEND, VID_FETCH, TSTATE, cnt[1], cnt[4:2]);
      end
    end
  endtask

  task automatic test_video_slots();
    int latches;
    logic exp_f;
    logic [1:0] exp_s;
    latches = 0;
    VID_ACTIVE = 1'b1;
    wait_cnt(5'd31);
    for (int c = 0; c < 32; c++) begin
      @(negedge OSC);
      if (c == 10) VID_ACTIVE = 1'b0;
      exp_f = (c < 16);
      exp_s = exp_f ? 2'(c / 4) : 2'd0;
      if (VID_LATCH) latches++;
      vectors++;
      if (VID_FETCH !== exp_f || VID_SLOT !== exp_s || VID_LATCH !== (exp_f && (c % 4 == 3))) begin
        miscompares++;
        $display("FAIL video_slot cnt=%0d got fetch=%b slot=%0d latch=%b want fetch=%b slot=%0d latch=%b",
                 c, VID_FETCH, VID_SLOT, VID_LATCH, exp_f, exp_s, exp_f && (c % 4 == 3));
      end
    end
    vectors++;
    if (latches != 4) begin
      miscompares++;
      $display("FAIL latch_count got %0d want 4", latches);
    end
    @(negedge OSC);
    vectors++;
    if (VID_FETCH !== 1'b0) begin
      miscompares++;
      $display("FAIL window_closed got fetch=%b want 0", VID_FETCH);
    end
    VID_ACTIVE = 1'b1;
  endtask

  task automatic test_mem_stall();
    logic exp_c;
    int cont_len;
    cont_len = 0;
    wait_cnt(5'd31);
    wait_cnt(5'd6);
    n_MREQ = 1'b0; A15 = 1'b0; A14 = 1'b1;
    for (int c = 7; c < 32; c++) begin
      @(negedge OSC);
      exp_c = (c >= 8 && c < 24);
      if (CONTEND) cont_len++;
      vectors++;
      if (CONTEND !== exp_c || CPU_CLK !== (exp_c ? 1'b1 : cnt[1])) begin
        miscompares++;
        $display("FAIL mem_stall cnt=%0d got cont=%b clk=%b want cont=%b clk=%b",
                 c, CONTEND, CPU_CLK, exp_c, exp_c ? 1'b1 : cnt[1]);
      end
      if (c == 26) n_MREQ = 1'b1;
    end
    vectors++;
    if (cont_len != 16) begin
      miscompares++;
      $display("FAIL mem_stall_len got %0d want 16", cont_len);
    end
  endtask

  task automatic test_no_stall();
    // Request at TS6 is past the contention window.
    wait_cnt(5'd22);
    n_MREQ = 1'b0; A15 = 1'b0; A14 = 1'b1;
    for (int c = 23; c < 32; c++) begin
      @(negedge OSC);
      vectors++;
      if (CONTEND !== 1'b0) begin
        miscompares++;
        $display("FAIL late_req cnt=%0d got cont=%b want 0", c, CONTEND);
      end
      if (c == 29) n_MREQ = 1'b1;
    end
    // Uncontended address space.
    wait_cnt(5'd6);
    n_MREQ = 1'b0; A14 = 1'b0;
    for (int c = 7; c < 24; c++) begin
      @(negedge OSC);
      vectors++;
      if (CONTEND !== 1'b0) begin
        miscompares++;
        $display("FAIL uncontended_addr cnt=%0d got cont=%b want 0", c, CONTEND);
      end
    end
    n_MREQ = 1'b1;
    // Closed window.
    VID_ACTIVE = 1'b0;
    wait_cnt(5'd31);
    wait_cnt(5'd6);
    n_MREQ = 1'b0; A14 = 1'b1;
    for (int c = 7; c < 24; c++) begin
      @(negedge OSC);
      vectors++;
      if (CONTEND !== 1'b0 || VID_FETCH !== 1'b0) begin
        miscompares++;
        $display("FAIL win_closed cnt=%0d got cont=%b fetch=%b want 0 0", c, CONTEND, VID_FETCH);
      end
    end
    n_MREQ = 1'b1;
    VID_ACTIVE = 1'b1;
  endtask

  task automatic test_io_stall();
    logic exp_c;
    int c;
    for (int pass = 0; pass < 2; pass++) begin
      wait_cnt(5'd30);
      n_IOREQ = 1'b0;
      A0 = (pass == 1);
      for (int j = 1; j < 32; j++) begin
        @(negedge OSC);
        c = (30 + j) % 32;
        exp_c = (pass == 0) && (j >= 2) && (c < 24);
        vectors++;
        if (CONTEND !== exp_c || CPU_CLK !== (exp_c ? 1'b1 : cnt[1])) begin
          miscompares++;
          $display("FAIL io_stall a0=%0d cnt=%0d got cont=%b clk=%b want cont=%b",
                   pass, c, CONTEND, CPU_CLK, exp_c);
        end
        if (c == 26) n_IOREQ = 1'b1;
      end
      A0 = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic exp_c;
    wait_cnt(5'd6);
    n_MREQ = 1'b0; A15 = 1'b0; A14 = 1'b1;
    for (int j = 1; j < 58; j++) begin
      @(negedge OSC);
      exp_c = (j >= 2 && j < 18);
      vectors++;
      if (CONTEND !== exp_c) begin
        miscompares++;
        $display("FAIL held_req step=%0d cnt=%0d got cont=%b want %b", j, cnt, CONTEND, exp_c);
      end
    end
    n_MREQ = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    wait_cnt(5'd31);
    wait_cnt(5'd6);
    n_MREQ = 1'b0; A15 = 1'b0; A14 = 1'b1;
    wait_cnt(5'd12);
    vectors++;
    if (CONTEND !== 1'b1 || VID_FETCH !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_state got cont=%b fetch=%b want 1 1", CONTEND, VID_FETCH);
    end
    n_RESET = 1'b0;
    #1;
    vectors++;
    if (CPU_CLK !== 1'b1 || CONTEND !== 1'b0 || TSTATE !== 3'd0 || VID_FETCH !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got clk=%b cont=%b ts=%0d fetch=%b want 1 0 0 0",
               CPU_CLK, CONTEND, TSTATE, VID_FETCH);
    end
    n_MREQ = 1'b1;
    @(negedge OSC);
    n_RESET = 1'b1;
    for (int c = 1; c < 33; c++) begin
      @(negedge OSC);
      vectors++;
      if (VID_FETCH !== (c == 32) || CONTEND !== 1'b0 || CPU_CLK !== cnt[1]) begin
        miscompares++;
        $display("FAIL post_reset cnt=%0d got fetch=%b cont=%b clk=%b want fetch=%b cont=0 clk=%b",
                 c % 32, VID_FETCH, CONTEND, CPU_CLK, (c == 32), cnt[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_video_slots();
    test_mem_stall();
    test_no_stall();
    test_io_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_contention_ctrl.md
Name: ula_contention_ctrl

Overview:
- Sequences the shared lower RAM (0x4000–0x7FFF) between the video fetcher and the CPU inside the ULA.
- Derives the CPU clock from OSC and generates the per-T-state video fetch slots.
- Stretches the CPU clock (contention) when the CPU touches contended memory or the ULA I/O port during a video fetch period.
- Sits between the video timing generator (supplies VID_ACTIVE) and the CPU bus decode.

Parameters:
STALL_END, 6, T-state index (0..7) at which contention releases within an 8-T-state period
FETCH_SLOTS, 4, number of consecutive T-states (from TS 0) the video owns RAM in a fetch period (1..4)
IO_CONTEND, 1, 1 = I/O cycles with A0=0 are contended; 0 = only memory cycles are contended

Ports:
OSC  in  1  master clock (14 MHz); all state updates on rising edge
n_RESET  in  1  asynchronous active-low reset
VID_ACTIVE  in  1  high while the video generator needs display fetches
n_MREQ  in  1  CPU memory request, active low
n_IOREQ  in  1  CPU I/O request, active low
A15  in  1  CPU address bit 15
A14  in  1  CPU address bit 14
A0  in  1  CPU address bit 0
CPU_CLK  out  1  CPU clock (OSC/4 nominal, held high while stalled)
CONTEND  out  1  stall active
VID_FETCH  out  1  video owns RAM this T-state
VID_SLOT  out  2  fetch index: 0=bitmap, 1=attr, 2=bitmap+1, 3=attr+1
VID_LATCH  out  1  one-OSC strobe to latch fetched byte
TSTATE  out  3  T-state position within the 8-T-state period

Behaviour:
- Interface: one clock (OSC). Reset n_RESET is asynchronous, active-low.
- Reset values: CNT=0, WIN=0, STALL=0, SERVED=0, CPU_CLK=1, CONTEND=0, VID_FETCH=0, VID_SLOT=0, VID_LATCH=0, TSTATE=0.
- Timebase: 5-bit free-running CNT (+1 per OSC, wraps 31→0). TS=CNT[4:2], SUB=CNT[1:0]. CNT never stalls.
- All outputs are registered and describe the CNT value present in the same cycle (decode from next-state).
- TSTATE equals TS.
- WIN: on the edge where CNT becomes 0, WIN<=VID_ACTIVE. WIN is constant for the whole 32-OSC period. VID_ACTIVE changes mid-period have no effect until the next wrap.
- Video slots: VID_FETCH=1 when WIN and TS<FETCH_SLOTS. VID_SLOT=TS[1:0] when VID_FETCH=1, else 0. VID_LATCH=1 when VID_FETCH and SUB==3.
- Contended request (REQ):
  - Memory: n_MREQ=0 and A15=0 and A14=1.
  - I/O: n_IOREQ=0 and A0=0, only when IO_CONTEND=1.
- Stall decision is made only on the edge where CNT enters SUB==0, i.e. the would-be falling CPU edge. No mid-phase glitches are allowed.
  - If REQ and !SERVED and WIN and TS(new)<STALL_END: STALL<=1.
  - Otherwise, if REQ: SERVED<=1.
- Stall release: STALL clears on the edge entering TS==STALL_END, SUB==0. SERVED<=1 on the same edge. The CPU clock falls in that same cycle.
- SERVED clears when n_MREQ=1 and n_IOREQ=1; this clear has priority over set. One CPU bus cycle is stalled at most once.
- CPU_CLK = 1 when STALL, else 0 for SUB∈{0,1} and 1 for SUB∈{2,3}. CONTEND=STALL.
- Stall length for a request at TS t (t<STALL_END) is STALL_END−t T-states. Requests at TS≥STALL_END, or with WIN=0, are never stalled.
- Requests in uncontended space (A14=0, or A15=1), and I/O cycles with A0=1, are never stalled.
- Asynchronous reset mid-stall: all state returns immediately to reset values and CPU_CLK=1. After release, CNT restarts at 0 and WIN=0 for the first period.

Test Plan:
- Reset, then VID_ACTIVE=0, no requests for 64 OSC → CPU_CLK period 4 OSC (low, low, high, high); CONTEND=0; VID_FETCH=0 throughout.
- VID_ACTIVE=1 before CNT wrap → in the next period VID_FETCH=1 for TS 0..3 (16 OSC); VID_SLOT steps 0,1,2,3; four VID_LATCH pulses at CNT=3,7,11,15.
- WIN=1, n_MREQ=0, A15=0, A14=1 asserted while TS=1 (high phase) → stall at entry to TS2. CONTEND=1 and CPU_CLK=1 for 16 OSC. Release at CNT=24 (TS6, SUB0).
- Same request at TS=6 → no stall. Same request with A14=0, or with WIN=0 → no stall.
- IO_CONTEND=1: n_IOREQ=0, A0=0 at TS0 → 24-OSC stall. With A0=1 → none. Hold n_MREQ low across the release → no second stall in the next period until the request deasserts.
- Assert n_RESET=0 mid-stall at CNT=12 → CPU_CLK=1, CONTEND=0, TSTATE=0 immediately. After release, the first period has VID_FETCH=0.
